c16_memory: RTL and testbench



---
 rtl/c16_memory.sv | 83 ++++++++
 tb/tb_c16_memory.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/c16_memory.sv
// C16 unified instruction/data RAM: 8192 x 16, single port, registered inputs and output (2-clock read latency).
// Optional program image preload is enabled by defining C16_MEM_INIT_EN (loads INIT_IMAGE into the array).
module c16_memory #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter     INIT_FILE = "c16_mem.hex",
    parameter int INIT_LEN  = 16,
    parameter logic [DATA_W-1:0] INIT_IMAGE [0:INIT_LEN-1] = '{default: '0}
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_rden,
    input  logic              i_wren,
    output logic [DATA_W-1:0] o_q
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] mem_t [0:DEPTH-1];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = '0;
        end
`ifdef C16_MEM_INIT_EN
        for (int i = 0; i < INIT_LEN; i++) begin
            if (i < DEPTH) begin
                m[i] = INIT_IMAGE[i];
            end
        end
`endif
        return m;
    endfunction

    // Words not covered by an image stay zero; with no image the CPU fetches 0x0000 forever.
    logic [DATA_W-1:0] r_mem [0:DEPTH-1] = init_mem();

    logic [ADDR_W-1:0] r_addr = '0;
    logic [DATA_W-1:0] r_data = '0;
    logic              r_rden = 1'b0;
    logic              r_wren = 1'b0;
    logic [DATA_W-1:0] r_q    = '0;

    logic w_unused_init_file;
    assign w_unused_init_file = ^INIT_FILE;

    // Stage 1: capture the request; anything presented during reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '0;
            r_data <= '0;
            r_rden <= 1'b0;
            r_wren <= 1'b0;
        end else begin
            r_addr <= i_address;
            r_data <= i_data;
            r_rden <= i_rden;
            r_wren <= i_wren;
        end
    end

    // Stage 2 write: no reset term, so a write captured just before reset still lands.
    always_ff @(posedge i_clk) begin
        if (r_wren) begin
            r_mem[r_addr] <= r_data;
        end
    end

    // Stage 2 read: non-blocking semantics give read-before-write on a same-address rd+wr.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (r_rden) begin
            r_q <= r_mem[r_addr];
        end
    end

    assign o_q = r_q;

endmodule

// File: tb/tb_c16_memory.sv
// Randomized + directed bench for c16_memory against a transaction-order reference model.
module tb_c16_memory;

    localparam int DEPTH = 8192;
`ifdef C16_MEM_INIT_EN
    localparam logic [15:0] INIT_W0 = 16'h0A12;
`else
    localparam logic [15:0] INIT_W0 = 16'h0000;
`endif
    localparam logic [15:0] TB_IMAGE [0:15] = '{0: 16'h0A12, default: 16'h0000};

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [12:0] address = 13'h0;
    logic [15:0] data    = 16'h0;
    logic        rden    = 1'b0;
    logic        wren    = 1'b0;
    logic [15:0] q;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: transactions take effect in issue order; a read sees every earlier write but not its own.
    logic [15:0] ref_mem [0:DEPTH-1];
    logic [15:0] exp_q  = 16'h0;
    bit          pend_v = 1'b0;
    bit          pend_rd, pend_wr;
    logic [12:0] pend_a;
    logic [15:0] pend_d;

    always #5 clk = ~clk;

    c16_memory #(
        .INIT_LEN   (16),
        .INIT_IMAGE (TB_IMAGE)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_address (address),
        .i_data    (data),
        .i_rden    (rden),
        .i_wren    (wren),
        .o_q       (q)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // One clock: present a request, let the model retire the previous one, compare q after the edge.
    task automatic cycle(input bit rst, input logic [12:0] a, input logic [15:0] d,
                         input bit rd, input bit wr);
        reset   = rst;
        address = a;
        data    = d;
        rden    = rd;
        wren    = wr;
        @(posedge clk);
        if (pend_v) begin
            if (pend_rd) exp_q = ref_mem[pend_a];
            if (pend_wr) ref_mem[pend_a] = pend_d;
        end
        if (rst) exp_q = 16'h0;
        pend_v  = !rst;
        pend_rd = rd;
        pend_wr = wr;
        pend_a  = a;
        pend_d  = d;
        @(negedge clk);
        check_eq("q_model", q, exp_q);
    endtask

    task automatic idle();
        cycle(1'b0, 13'($urandom), 16'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
        ref_mem[0] = INIT_W0;

        #1;
        check_eq("powerup_q", q, 16'h0);

        // First read of word 0 before anything is written
        cycle(1'b0, 13'h0000, 16'h0, 1'b1, 1'b0);
        idle();
        check_eq("init_word0", q, INIT_W0);

        // Reset with a write request on the pins: must be ignored
        cycle(1'b1, 13'h0030, 16'hDEAD, 1'b1, 1'b1);
        cycle(1'b1, 13'h0030, 16'hDEAD, 1'b1, 1'b1);
        check_eq("reset_q", q, 16'h0);

        // Write then read latency
        cycle(1'b0, 13'h0005, 16'hBEEF, 1'b0, 1'b1);
        idle();
        cycle(1'b0, 13'h0005, 16'h0, 1'b1, 1'b0);
        check_eq("rd_lat_early", q, 16'h0);
        idle();
        check_eq("rd_lat_2clk", q, 16'hBEEF);

        // Pipelined reads on consecutive cycles
        cycle(1'b0, 13'h0000, 16'h1111, 1'b0, 1'b1);
        cycle(1'b0, 13'h1FFF, 16'h2222, 1'b0, 1'b1);
        cycle(1'b0, 13'h0000, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 13'h1FFF, 16'h0, 1'b1, 1'b0);
        check_eq("pipe_0", q, 16'h1111);
        cycle(1'b0, 13'h0005, 16'h0, 1'b1, 1'b0);
        check_eq("pipe_1fff", q, 16'h2222);
        idle();
        check_eq("pipe_5", q, 16'hBEEF);

        // Same-cycle read and write: old word returned
        cycle(1'b0, 13'h0010, 16'h1234, 1'b0, 1'b1);
        cycle(1'b0, 13'h0010, 16'h5678, 1'b1, 1'b1);
        idle();
        check_eq("rbw_old", q, 16'h1234);
        cycle(1'b0, 13'h0010, 16'h0, 1'b1, 1'b0);
        idle();
        check_eq("rbw_new", q, 16'h5678);

        // rden low: q holds
        cycle(1'b0, 13'h0005, 16'h0, 1'b1, 1'b0);
        idle();
        for (int i = 0; i < 20; i++) idle();
        check_eq("hold_q", q, 16'hBEEF);
        cycle(1'b0, 13'h0000, 16'h0, 1'b1, 1'b0);
        idle();
        check_eq("hold_contents", q, 16'h1111);

        // Reset one cycle after read issue discards the read
        cycle(1'b0, 13'h0005, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 13'h0030, 16'hDEAD, 1'b1, 1'b1);
        check_eq("reset_mid_read", q, 16'h0);
        // Write captured just before reset still commits
        cycle(1'b0, 13'h0020, 16'hCAFE, 1'b0, 1'b1);
        cycle(1'b1, 13'h0020, 16'h0BAD, 1'b1, 1'b1);
        cycle(1'b0, 13'h0005, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 13'h0020, 16'h0, 1'b1, 1'b0);
        check_eq("after_reset_5", q, 16'hBEEF);
        cycle(1'b0, 13'h0030, 16'h0, 1'b1, 1'b0);
        check_eq("write_at_reset_edge", q, 16'hCAFE);
        idle();
        check_eq("reset_inputs_ignored", q, 16'h0);

        // Random traffic over a small address window plus the extremes
        for (int i = 0; i < 400; i++) begin
            logic [12:0] a;
            if ($urandom_range(0, 3) == 0)
                a = ($urandom_range(0, 1) == 0) ? 13'h0000 : 13'h1FFF;
            else
                a = 13'($urandom_range(0, 31));
            cycle(($urandom_range(0, 49) == 0), a, 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
